// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU opcode, shifter and result types for the ALU control decoder and alu_exec_stage.
// ALU_ITER_SHIFT_EN (defined elsewhere) selects the iterative shifter in alu_shift_unit.
package alu_exec_stage_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned SHAMT_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_ADDU = 4'h1,
      ALU_SUB  = 4'h2,
      ALU_SUBU = 4'h3,
      ALU_AND  = 4'h4,
      ALU_OR   = 4'h5,
      ALU_XOR  = 4'h6,
      ALU_NOR  = 4'h7,
      ALU_SLT  = 4'h8,
      ALU_SLTU = 4'h9,
      ALU_SLL  = 4'hA,
      ALU_SLLV = 4'hB,
      ALU_SRL  = 4'hC,
      ALU_SRLV = 4'hD,
      ALU_SRA  = 4'hE,
      ALU_SRAV = 4'hF
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_op_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic            overflow;
      logic            zero;
   } alu_out_t;

   // Codes A..F are the shifts; the odd ones take their amount from src_a.
   function automatic logic is_shift(input alu_ctrl_e c);
      return c[3] & (c[2] | c[1]);
   endfunction

   function automatic logic shift_is_var(input alu_ctrl_e c);
      return c[0];
   endfunction

   function automatic shift_op_e shift_op(input alu_ctrl_e c);
      case (c)
         ALU_SLL, ALU_SLLV: return SH_SLL;
         ALU_SRL, ALU_SRLV: return SH_SRL;
         default:           return SH_SRA;
      endcase
   endfunction

endpackage

// File: rtl/alu_exec_stage_shift_unit.sv
// alu_shift_unit: barrel shifter by default; ALU_ITER_SHIFT_EN selects a one-bit-per-cycle shifter.
// done qualifies result; the iterative form holds its last step while hold is asserted.
module alu_shift_unit
   import alu_exec_stage_pkg::*;
(
`ifdef ALU_ITER_SHIFT_EN
   input  logic               clk,
   input  logic               rst,
   input  logic               kill,
   input  logic               hold,
`endif
   input  logic               start,
   input  shift_op_e          op,
   input  logic [SHAMT_W-1:0] amount,
   input  logic [XLEN-1:0]    operand,
   output logic               done,
   output logic [XLEN-1:0]    result
);

`ifdef ALU_ITER_SHIFT_EN
   logic [SHAMT_W-1:0] cnt_q;
   logic [XLEN-1:0]    data_q;
   shift_op_e          op_q;
   logic [XLEN-1:0]    step_c;
   logic               zero_amt_c;

   always_comb begin
      case (op_q)
         SH_SLL:  step_c = {data_q[XLEN-2:0], 1'b0};
         SH_SRL:  step_c = {1'b0, data_q[XLEN-1:1]};
         default: step_c = {data_q[XLEN-1], data_q[XLEN-1:1]};
      endcase
   end

   assign zero_amt_c = start & (amount == '0);
   assign done       = zero_amt_c | (cnt_q == SHAMT_W'(1));
   assign result     = zero_amt_c ? operand : step_c;

   // The final (cnt==1) step is taken by the consumer, so cnt parks at 1 while held.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         cnt_q  <= '0;
         data_q <= '0;
         op_q   <= SH_SLL;
      end else if (start && (amount != '0)) begin
         cnt_q  <= amount;
         data_q <= operand;
         op_q   <= op;
      end else if (cnt_q > SHAMT_W'(1)) begin
         cnt_q  <= cnt_q - SHAMT_W'(1);
         data_q <= step_c;
      end else if ((cnt_q == SHAMT_W'(1)) && !hold) begin
         cnt_q  <= '0;
      end
   end
`else
   always_comb begin
      case (op)
         SH_SLL:  result = operand << amount;
         SH_SRL:  result = operand >> amount;
         default: result = XLEN'($signed(operand) >>> amount);
      endcase
   end

   assign done = start;
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with valid/ready on both sides and a one-entry output register.
// ALU_ITER_SHIFT_EN: shifts by n>=1 run through the SHIFT state, otherwise all ops take one cycle.
module alu_exec_stage
   import alu_exec_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_ctrl,
   input  logic [XLEN-1:0]    src_a,
   input  logic [XLEN-1:0]    src_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    result,
   output logic               overflow,
   output logic               zero
);

   state_e          state_q;
   logic            out_valid_q;
   alu_out_t        out_q;
   alu_out_t        out_d;

   alu_ctrl_e       ctrl_c;
   logic [XLEN-1:0] sum_c;
   logic [XLEN-1:0] diff_c;
   logic [XLEN-1:0] alu_res_c;
   logic            alu_ovf_c;
   logic            is_sh_c;
   logic            free_c;
   logic            accept_c;
   logic            wr_c;
   logic            go_shift_c;
   logic            sh_start_c;
   logic            sh_done;
   logic [XLEN-1:0] sh_result;
   logic [SHAMT_W-1:0] sh_amount_c;

   assign ctrl_c   = alu_ctrl_e'(alu_ctrl);
   assign is_sh_c  = is_shift(ctrl_c);
   assign free_c   = ~out_valid_q | out_ready;
   assign in_ready = (state_q == S_IDLE) & free_c & ~flush & ~rst;
   assign accept_c = in_valid & in_ready;

   assign sum_c  = src_a + src_b;
   assign diff_c = src_a - src_b;

   // Non-shift datapath; overflow only for the signed ADD/SUB.
   always_comb begin
      alu_res_c = '0;
      alu_ovf_c = 1'b0;
      case (ctrl_c)
         ALU_ADD: begin
            alu_res_c = sum_c;
            alu_ovf_c = (src_a[XLEN-1] == src_b[XLEN-1]) & (sum_c[XLEN-1] != src_a[XLEN-1]);
         end
         ALU_ADDU: alu_res_c = sum_c;
         ALU_SUB: begin
            alu_res_c = diff_c;
            alu_ovf_c = (src_a[XLEN-1] != src_b[XLEN-1]) & (diff_c[XLEN-1] != src_a[XLEN-1]);
         end
         ALU_SUBU: alu_res_c = diff_c;
         ALU_AND:  alu_res_c = src_a & src_b;
         ALU_OR:   alu_res_c = src_a | src_b;
         ALU_XOR:  alu_res_c = src_a ^ src_b;
         ALU_NOR:  alu_res_c = ~(src_a | src_b);
         ALU_SLT:  alu_res_c = XLEN'($signed(src_a) < $signed(src_b));
         ALU_SLTU: alu_res_c = XLEN'(src_a < src_b);
         default:  alu_res_c = '0;
      endcase
   end

   assign sh_start_c  = accept_c & is_sh_c;
   assign sh_amount_c = shift_is_var(ctrl_c) ? src_a[SHAMT_W-1:0] : shamt;

   alu_shift_unit u_shift (
`ifdef ALU_ITER_SHIFT_EN
      .clk     (clk),
      .rst     (rst),
      .kill    (flush),
      .hold    (~free_c),
`endif
      .start   (sh_start_c),
      .op      (shift_op(ctrl_c)),
      .amount  (sh_amount_c),
      .operand (src_b),
      .done    (sh_done),
      .result  (sh_result)
   );

   // Output-register write: immediate ops on accept, iterative shifts once the last step is free.
   always_comb begin
      wr_c       = 1'b0;
      go_shift_c = 1'b0;
      out_d      = '{result: alu_res_c, overflow: alu_ovf_c, zero: (alu_res_c == '0)};
      if (is_sh_c || (state_q == S_SHIFT)) begin
         out_d = '{result: sh_result, overflow: 1'b0, zero: (sh_result == '0)};
      end
      if (state_q == S_IDLE) begin
         wr_c       = accept_c & (~is_sh_c | sh_done);
         go_shift_c = sh_start_c & ~sh_done;
      end else begin
         wr_c = sh_done & free_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_q       <= '{result: '0, overflow: 1'b0, zero: 1'b1};
      end else if (flush) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
      end else begin
         if (go_shift_c) begin
            state_q <= S_SHIFT;
         end else if ((state_q == S_SHIFT) && wr_c) begin
            state_q <= S_IDLE;
         end
         if (wr_c) begin
            out_valid_q <= 1'b1;
            out_q       <= out_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = out_q.result;
   assign overflow  = out_q.overflow;
   assign zero      = out_q.zero;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table through a scoreboard plus handshake/flush/reset sequences.
// Expected shift latency follows ALU_ITER_SHIFT_EN when the bench is built with it.
module tb_alu_exec_stage;
   import alu_exec_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, overflow, zero;
   logic [3:0]  alu_ctrl;
   logic [31:0] src_a, src_b, result;
   logic [4:0]  shamt;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   exp_t        sb[$];
   exp_t        sb_e;
   logic [31:0] cur_res;
   logic        cur_ovf;
   int          checks = 0;
   int          errors = 0;

`ifdef ALU_ITER_SHIFT_EN
   localparam int SRA4_LAT  = 5;
   localparam int BUSY_RDY  = 0;
`else
   localparam int SRA4_LAT  = 1;
   localparam int BUSY_RDY  = 1;
`endif

   alu_exec_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .src_a     (src_a),
      .src_b     (src_b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: push on accept, pop on consume, drop everything on flush/reset.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got %h expected no result", result);
            end else begin
               sb_e = sb.pop_front();
               check("sb_result", result, sb_e.res);
               check("sb_overflow", 32'(overflow), 32'(sb_e.ovf));
               check("sb_zero", 32'(zero), 32'(sb_e.res == 32'h0));
            end
         end
         if (in_valid && in_ready) sb.push_back('{cur_res, cur_ovf});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] er, input logic eo);
      alu_ctrl = c;
      src_a    = a;
      src_b    = b;
      shamt    = sh;
      cur_res  = er;
      cur_ovf  = eo;
      in_valid = 1'b1;
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check(name, 32'(in_ready), 32'h1);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         step();
         n++;
      end
      check("drain", 32'(sb.size()), 32'h0);
   endtask

   vec_t vt[20];
   int   lat;

   initial begin
      vt[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1};
      vt[1]  = '{4'h1, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0};
      vt[2]  = '{4'h2, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0};
      vt[3]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
      vt[4]  = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0};
      vt[5]  = '{4'hE, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
      vt[6]  = '{4'hD, 32'h00000025, 32'h000000FF, 5'd0,  32'h00000007, 1'b0};
      vt[7]  = '{4'hD, 32'h00000020, 32'h12345678, 5'd9,  32'h12345678, 1'b0};
      vt[8]  = '{4'h2, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1};
      vt[9]  = '{4'h3, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0};
      vt[10] = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0};
      vt[11] = '{4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0};
      vt[12] = '{4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0};
      vt[13] = '{4'h7, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0};
      vt[14] = '{4'hA, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
      vt[15] = '{4'hB, 32'h00000003, 32'h0000000F, 5'd0,  32'h00000078, 1'b0};
      vt[16] = '{4'hC, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
      vt[17] = '{4'hF, 32'h0000001F, 32'h80000000, 5'd0,  32'hFFFFFFFF, 1'b0};
      vt[18] = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0};
      vt[19] = '{4'h0, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_ctrl = 4'h0; src_a = '0; src_b = '0; shamt = '0; cur_res = '0; cur_ovf = 1'b0;
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_result", result, 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      check("rst_zero", 32'(zero), 32'h1);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'h1);

      // Table vectors issued back to back.
      for (int i = 0; i < 20; i++) begin
         drive(vt[i].ctrl, vt[i].a, vt[i].b, vt[i].sh, vt[i].res, vt[i].ovf);
         wait_ready("tbl_ready");
         step();
      end
      in_valid = 1'b0;
      drain();

      // Latency of ADD and SRA by 4; SRLV by 0 is always single cycle.
      drive(4'h0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1);
      step();
      in_valid = 1'b0;
      check("add_latency_valid", 32'(out_valid), 32'h1);
      drain();
      drive(4'hE, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
      check("sra_in_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      lat = 1;
      check("sra_busy_in_ready", 32'(in_ready), 32'(BUSY_RDY));
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check("sra_latency", 32'(lat), 32'(SRA4_LAT));
      drain();
      drive(4'hD, 32'h00000020, 32'h12345678, 5'd7, 32'h12345678, 1'b0);
      step();
      in_valid = 1'b0;
      check("srlv0_latency_valid", 32'(out_valid), 32'h1);
      drain();

      // Backpressure: result held, new op blocked, then consume and accept together.
      out_ready = 1'b0;
      drive(4'h0, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0);
      step();
      drive(4'h6, 32'h0F0F0F0F, 32'hFFFF0000, 5'd0, 32'hF0F00F0F, 1'b0);
      for (int k = 0; k < 3; k++) begin
         check("bp_in_ready", 32'(in_ready), 32'h0);
         check("bp_result_hold", result, 32'h3);
         check("bp_out_valid", 32'(out_valid), 32'h1);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      check("bp_new_valid", 32'(out_valid), 32'h1);
      check("bp_new_result", result, 32'hF0F00F0F);
      drain();

      // Flush together with in_valid: nothing accepted.
      drive(4'h0, 32'h4, 32'h4, 5'd0, 32'h8, 1'b0);
      flush = 1'b1;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'h0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_iv_valid", 32'(out_valid), 32'h0);
      step();
      check("flush_iv_valid2", 32'(out_valid), 32'h0);

      // Flush while a shift is in flight (or held at the output).
      out_ready = 1'b0;
      drive(4'hE, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("flush_sh_valid", 32'(out_valid), 32'h0);
         step();
      end
      check("flush_sh_idle", 32'(in_ready), 32'h1);

      // Reset in the middle of a shift.
      drive(4'h0, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0);
      step();
      in_valid = 1'b0;
      drain();
      drive(4'hE, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check("rst_mid_in_ready", 32'(in_ready), 32'h0);
      step();
      check("rst_mid_valid", 32'(out_valid), 32'h0);
      check("rst_mid_result", result, 32'h0);
      check("rst_mid_overflow", 32'(overflow), 32'h0);
      check("rst_mid_zero", 32'(zero), 32'h1);
      rst = 1'b0;
      #1;
      check("rst_mid_idle", 32'(in_ready), 32'h1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("rst_mid_quiet", 32'(out_valid), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
